// File: rtl/airlock_pkg.sv
// Shared state encoding, output bundle and defaults for the airlock sequencer.
package airlock_pkg;

   localparam int STATE_W       = 3;
   localparam int WD_CYCLES_DEF = 64;
   localparam int WD_W_DEF      = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_EMPTY = 3'd1,
      ST_OUTER = 3'd2,
      ST_FILL  = 3'd3,
      ST_INNER = 3'd4,
      ST_FAULT = 3'd7
   } state_t;

   typedef struct packed {
      logic pump_in;
      logic pump_out;
      logic inner_open;
      logic outer_open;
      logic busy;
      logic fault;
   } out_t;

   localparam out_t OUT_NONE = out_t'(6'b000000);

   // Phases that run the shared timer and are guarded by the watchdog.
   function automatic logic is_timed(input state_t s);
      logic r;
      case (s)
         ST_EMPTY, ST_OUTER, ST_FILL, ST_INNER: r = 1'b1;
         default:                               r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/airlock_wdog.sv
// Per-phase watchdog: counts cycles spent in a timed phase and flags the
// cycle in which the limit is reached.
module airlock_wdog
   import airlock_pkg::*;
#(
   parameter int WD_CYCLES = WD_CYCLES_DEF,
   parameter int WD_W      = WD_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   output logic [WD_W-1:0] count,
   output logic            expired
);

   // count holds (cycles already spent in the phase); the WD_CYCLES-th cycle reads LAST
   localparam logic [WD_W-1:0] LAST = WD_W'(WD_CYCLES - 1);
   localparam logic [WD_W-1:0] ONE  = {{(WD_W-1){1'b0}}, 1'b1};
   localparam logic [WD_W-1:0] ZERO = {WD_W{1'b0}};

   logic [WD_W-1:0] count_r;

   // Phase cycle counter, saturating so it can never wrap back under the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= ZERO;
      end else if (clear) begin
         count_r <= ZERO;
      end else if (enable && (count_r < LAST)) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count   = count_r;
   assign expired = (count_r >= LAST);

endmodule

// File: rtl/airlock_sequencer.sv
// Two-door airlock controller: sequences pumps and door enables through
// timer-paced phases, trapping into FAULT if the timer never completes.
module airlock_sequencer
   import airlock_pkg::*;
#(
   parameter int WD_CYCLES = WD_CYCLES_DEF,
   parameter int WD_W      = WD_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               arrive,
   input  logic               depart,
   input  logic               t_done,
   output logic               t_start,
   output logic               pump_in,
   output logic               pump_out,
   output logic               inner_open,
   output logic               outer_open,
   output logic               busy,
   output logic               fault,
   output logic [STATE_W-1:0] state
);

   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

   state_t          state_r;
   state_t          state_next_s;
   logic            dir_r;
   logic            dir_next_s;
   logic            armed_r;
   logic            armed_next_s;
   logic            t_start_r;
   logic            t_start_next_s;
   out_t            out_r;
   out_t            out_next_s;
   logic            phase_done_s;
   logic            wd_clear_s;
   logic            wd_enable_s;
   logic            wd_expired_s;
   logic            wd_trip_s;
   logic [WD_W-1:0] wd_count_s;

   airlock_wdog #(
      .WD_CYCLES (WD_CYCLES),
      .WD_W      (WD_W)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear_s),
      .enable  (wd_enable_s),
      .count   (wd_count_s),
      .expired (wd_expired_s)
   );

   assign wd_clear_s   = (state_next_s != state_r);
   assign wd_enable_s  = is_timed(state_r);
   // A counter found beyond the limit is treated as expired too, not just the exact match.
   assign wd_trip_s    = wd_expired_s || (wd_count_s > WD_LAST);
   // t_done is stale during the first cycle of a phase, so only an armed phase may advance.
   assign phase_done_s = armed_r && t_done;

   // State register with the direction and armed flags that travel with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         dir_r   <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         dir_r   <= dir_next_s;
         armed_r <= armed_next_s;
      end
   end

   // Next-state logic; a completed phase takes priority over a watchdog trip.
   always_comb begin
      state_next_s = state_r;
      dir_next_s   = dir_r;
      case (state_r)
         ST_IDLE: begin
            if (depart) begin
               state_next_s = ST_INNER;
               dir_next_s   = 1'b1;
            end else if (arrive) begin
               state_next_s = ST_EMPTY;
               dir_next_s   = 1'b0;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EMPTY: begin
            if (phase_done_s)   state_next_s = ST_OUTER;
            else if (wd_trip_s) state_next_s = ST_FAULT;
            else                state_next_s = ST_EMPTY;
         end
         ST_OUTER: begin
            if (phase_done_s)   state_next_s = ST_FILL;
            else if (wd_trip_s) state_next_s = ST_FAULT;
            else                state_next_s = ST_OUTER;
         end
         ST_FILL: begin
            if (phase_done_s)   state_next_s = dir_r ? ST_IDLE : ST_INNER;
            else if (wd_trip_s) state_next_s = ST_FAULT;
            else                state_next_s = ST_FILL;
         end
         ST_INNER: begin
            if (phase_done_s)   state_next_s = dir_r ? ST_EMPTY : ST_IDLE;
            else if (wd_trip_s) state_next_s = ST_FAULT;
            else                state_next_s = ST_INNER;
         end
         ST_FAULT: begin
            state_next_s = ST_FAULT;
         end
         default: begin
            state_next_s = ST_FAULT;
         end
      endcase
   end

   // Output decode of the upcoming state, so registered outputs line up with state.
   always_comb begin
      out_next_s      = OUT_NONE;
      out_next_s.busy = (state_next_s != ST_IDLE);
      t_start_next_s  = is_timed(state_next_s) && (state_next_s != state_r);
      armed_next_s    = is_timed(state_next_s) && (state_next_s == state_r);
      case (state_next_s)
         ST_IDLE:  out_next_s.busy       = 1'b0;
         ST_EMPTY: out_next_s.pump_out   = 1'b1;
         ST_OUTER: out_next_s.outer_open = 1'b1;
         ST_FILL:  out_next_s.pump_in    = 1'b1;
         ST_INNER: out_next_s.inner_open = 1'b1;
         ST_FAULT: out_next_s.fault      = 1'b1;
         default:  out_next_s.fault      = 1'b1;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_r     <= OUT_NONE;
         t_start_r <= 1'b0;
      end else begin
         out_r     <= out_next_s;
         t_start_r <= t_start_next_s;
      end
   end

   assign t_start    = t_start_r;
   assign pump_in    = out_r.pump_in;
   assign pump_out   = out_r.pump_out;
   assign inner_open = out_r.inner_open;
   assign outer_open = out_r.outer_open;
   assign busy       = out_r.busy;
   assign fault      = out_r.fault;
   assign state      = state_r;

endmodule
